// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem: arbiter FSM encoding and sizing helpers.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_t;

  localparam int ARB_STATE_W = 2;

  // Width of a counter that must hold values 0..max_cnt inclusive.
  function automatic int burst_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational priority decision: B wins ties unless its burst allowance is used up.
module arb_pick (
  input  logic a_req,
  input  logic b_req,
  input  logic burst_full,
  output logic grant_a,
  output logic grant_b
);

  logic w_a_forced;

  always_comb begin
    w_a_forced = a_req && burst_full;
    grant_b    = b_req && !w_a_forced;
    grant_a    = a_req && !grant_b;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of a single-ported memory: A = instruction fetch, B = data.
// Handshake: a client holds read/write (and address/wdata) high until its x_resp pulse;
// the memory sees a strobe held from the serve cycle until the cycle mem_resp is high.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int B_BURST    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_read,
  input  logic [ADDR_WIDTH-1:0]  a_address,
  output logic [DATA_WIDTH-1:0]  a_rdata,
  output logic                   a_resp,
  input  logic                   b_read,
  input  logic                   b_write,
  input  logic [ADDR_WIDTH-1:0]  b_address,
  input  logic [DATA_WIDTH-1:0]  b_wdata,
  output logic [DATA_WIDTH-1:0]  b_rdata,
  output logic                   b_resp,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_resp,
  output logic [ARB_STATE_W-1:0] dbg_state
);

  localparam int             BW        = burst_width(B_BURST);
  localparam logic [BW-1:0]  BURST_MAX = BW'(B_BURST);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [BW-1:0]         r_burst_cnt;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  logic w_b_req;
  logic w_burst_full;
  logic w_grant_a;
  logic w_grant_b;
  logic w_idle;
  logic w_take_a;
  logic w_take_b;
  logic w_serving;

  assign w_b_req      = b_read || b_write;
  assign w_burst_full = (r_burst_cnt == BURST_MAX);
  assign w_idle       = (r_state == IDLE);
  assign w_take_a     = w_idle && w_grant_a;
  assign w_take_b     = w_idle && w_grant_b;

  arb_pick u_pick (
    .a_req      (a_read),
    .b_req      (w_b_req),
    .burst_full (w_burst_full),
    .grant_a    (w_grant_a),
    .grant_b    (w_grant_b)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_b) begin
          w_next_state = SERVE_B;
        end else if (w_grant_a) begin
          w_next_state = SERVE_A;
        end
      end
      SERVE_A, SERVE_B: begin
        if (mem_resp) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM: outputs. Strobes follow the state so an async reset drops them at once.
  always_comb begin
    w_serving   = (r_state == SERVE_A) || (r_state == SERVE_B);
    mem_read    = w_serving && !r_op_write;
    mem_write   = w_serving && r_op_write;
    mem_address = r_address;
    mem_wdata   = r_wdata;
    a_resp      = (r_state == SERVE_A) && mem_resp;
    b_resp      = (r_state == SERVE_B) && mem_resp;
    a_rdata     = a_resp ? mem_rdata : r_a_rdata;
    b_rdata     = b_resp ? mem_rdata : r_b_rdata;
    dbg_state   = r_state;
  end

  // Request registers freeze the granted access so client-side changes cannot leak onto the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_write <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
    end else if (w_take_b) begin
      r_op_write <= b_write;
      r_address  <= b_address;
      r_wdata    <= b_wdata;
    end else if (w_take_a) begin
      r_op_write <= 1'b0;
      r_address  <= a_address;
      r_wdata    <= '0;
    end
  end

  // Counts B wins while A waits; once it reaches the limit A gets the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (!a_read || w_take_a) begin
      r_burst_cnt <= '0;
    end else if (w_take_b && !w_burst_full) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (a_resp) begin
        r_a_rdata <= mem_rdata;
      end
      if (b_resp) begin
        r_b_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_A = 2'd1;
  localparam logic [1:0] S_B = 2'd2;

  typedef struct {
    logic        a_rd;
    logic [15:0] a_ad;
    logic        b_rd;
    logic        b_wr;
    logic [15:0] b_ad;
    logic [15:0] b_wd;
    logic [15:0] m_rd;
    logic        m_rs;
    logic        x_rd;
    logic        x_wr;
    logic [15:0] x_ad;
    logic [15:0] x_wd;
    logic        x_ar;
    logic [15:0] x_ard;
    logic        x_br;
    logic [15:0] x_brd;
    logic [1:0]  x_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_read = 1'b0;
  logic [15:0] a_address = '0;
  logic [15:0] a_rdata;
  logic        a_resp;
  logic        b_read = 1'b0;
  logic        b_write = 1'b0;
  logic [15:0] b_address = '0;
  logic [15:0] b_wdata = '0;
  logic [15:0] b_rdata;
  logic        b_resp;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic [1:0]  dbg_state;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   resp_cnt;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .B_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_read      (a_read),
    .a_address   (a_address),
    .a_rdata     (a_rdata),
    .a_resp      (a_resp),
    .b_read      (b_read),
    .b_write     (b_write),
    .b_address   (b_address),
    .b_wdata     (b_wdata),
    .b_rdata     (b_rdata),
    .b_resp      (b_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic a_rd, input logic [15:0] a_ad,
                     input logic b_rd, input logic b_wr, input logic [15:0] b_ad, input logic [15:0] b_wd,
                     input logic [15:0] m_rd, input logic m_rs,
                     input logic x_rd, input logic x_wr, input logic [15:0] x_ad, input logic [15:0] x_wd,
                     input logic x_ar, input logic [15:0] x_ard, input logic x_br, input logic [15:0] x_brd,
                     input logic [1:0] x_st);
    vec_t v;
    v.a_rd = a_rd; v.a_ad = a_ad; v.b_rd = b_rd; v.b_wr = b_wr; v.b_ad = b_ad; v.b_wd = b_wd;
    v.m_rd = m_rd; v.m_rs = m_rs; v.x_rd = x_rd; v.x_wr = x_wr; v.x_ad = x_ad; v.x_wd = x_wd;
    v.x_ar = x_ar; v.x_ard = x_ard; v.x_br = x_br; v.x_brd = x_brd; v.x_st = x_st;
    vecs.push_back(v);
  endtask

  // Driver: inputs change just after the rising edge
  task automatic drive(input logic a_rd, input logic [15:0] a_ad, input logic b_rd, input logic b_wr,
                       input logic [15:0] b_ad, input logic [15:0] b_wd, input logic [15:0] m_rd, input logic m_rs);
    @(posedge clk);
    #1;
    a_read = a_rd; a_address = a_ad; b_read = b_rd; b_write = b_wr;
    b_address = b_ad; b_wdata = b_wd; mem_rdata = m_rd; mem_resp = m_rs;
  endtask

  // Scoreboard: compare every output against the expected record on the falling edge
  task automatic check_all(input int idx, input vec_t v);
    chk("mem_read", idx, 16'(mem_read), 16'(v.x_rd));
    chk("mem_write", idx, 16'(mem_write), 16'(v.x_wr));
    chk("mem_address", idx, mem_address, v.x_ad);
    chk("mem_wdata", idx, mem_wdata, v.x_wd);
    chk("a_resp", idx, 16'(a_resp), 16'(v.x_ar));
    chk("a_rdata", idx, a_rdata, v.x_ard);
    chk("b_resp", idx, 16'(b_resp), 16'(v.x_br));
    chk("b_rdata", idx, b_rdata, v.x_brd);
    chk("state", idx, 16'(dbg_state), 16'(v.x_st));
    n_vec++;
  endtask

  initial begin
    vec_t v;

    // A read of 0x1000; A drops its request mid-service; mem_resp on the third strobe cycle.
    add(1, 16'h1000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, S_I);
    add(1, 16'h1000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h1000, 16'h0000, 0, 16'h0000, 0, 16'h0000, S_A);
    add(0, 16'h1000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h1000, 16'h0000, 0, 16'h0000, 0, 16'h0000, S_A);
    add(0, 16'h1000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 1, 0, 16'h1000, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, S_A);
    add(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h5555, 0, 0, 0, 16'h1000, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, S_I);
    // A and B together: B write wins, A follows after one idle cycle.
    add(1, 16'h1100, 0, 1, 16'h2000, 16'h1234, 16'h0000, 0, 0, 0, 16'h1000, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, S_I);
    add(1, 16'h1100, 0, 1, 16'h2000, 16'h1234, 16'h7777, 1, 0, 1, 16'h2000, 16'h1234, 0, 16'hBEEF, 1, 16'h7777, S_B);
    add(1, 16'h1100, 0, 0, 16'h2000, 16'h1234, 16'h0000, 0, 0, 0, 16'h2000, 16'h1234, 0, 16'hBEEF, 0, 16'h7777, S_I);
    add(1, 16'h1100, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, 1, 1, 0, 16'h1100, 16'h0000, 1, 16'hA5A5, 0, 16'h7777, S_A);
    // mem_resp while idle must be ignored.
    add(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 0, 0, 16'h1100, 16'h0000, 0, 16'hA5A5, 0, 16'h7777, S_I);
    // B burst with A pending: B,B,B,B,A,B.
    for (int i = 0; i < 4; i++) begin
      add(1, 16'h1200, 1, 0, 16'h3100 + 16'(i), 16'h0000, 16'h0000, 0,
          0, 0, (i == 0) ? 16'h1100 : 16'h3100 + 16'(i - 1), 16'h0000,
          0, 16'hA5A5, 0, (i == 0) ? 16'h7777 : 16'h0B00 + 16'(i - 1), S_I);
      add(1, 16'h1200, 1, 0, 16'h3100 + 16'(i), 16'h0000, 16'h0B00 + 16'(i), 1,
          1, 0, 16'h3100 + 16'(i), 16'h0000, 0, 16'hA5A5, 1, 16'h0B00 + 16'(i), S_B);
    end
    add(1, 16'h1200, 1, 0, 16'h3104, 16'h0000, 16'h0000, 0, 0, 0, 16'h3103, 16'h0000, 0, 16'hA5A5, 0, 16'h0B03, S_I);
    add(1, 16'h1200, 1, 0, 16'h3104, 16'h0000, 16'h0A11, 1, 1, 0, 16'h1200, 16'h0000, 1, 16'h0A11, 0, 16'h0B03, S_A);
    add(1, 16'h1200, 1, 0, 16'h3104, 16'h0000, 16'h0000, 0, 0, 0, 16'h1200, 16'h0000, 0, 16'h0A11, 0, 16'h0B03, S_I);
    add(0, 16'h0000, 1, 0, 16'h3104, 16'h0000, 16'h0B04, 1, 1, 0, 16'h3104, 16'h0000, 0, 16'h0A11, 1, 16'h0B04, S_B);
    add(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h3104, 16'h0000, 0, 16'h0A11, 0, 16'h0B04, S_I);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    v = '{default: '0};
    v.x_st = S_I;
    check_all(-1, v);

    foreach (vecs[i]) begin
      drive(vecs[i].a_rd, vecs[i].a_ad, vecs[i].b_rd, vecs[i].b_wr,
            vecs[i].b_ad, vecs[i].b_wd, vecs[i].m_rd, vecs[i].m_rs);
      @(negedge clk);
      check_all(i, vecs[i]);
    end

    // B moves its address mid-service; the bus keeps the latched 0x3000.
    drive(0, 0, 1, 0, 16'h3000, 16'h0000, 16'h0000, 0);
    @(negedge clk); chk("addr_hold_idle_state", 100, 16'(dbg_state), 16'(S_I)); n_vec++;
    drive(0, 0, 1, 0, 16'h3002, 16'h0000, 16'h0000, 0);
    @(negedge clk); chk("addr_hold_1", 101, mem_address, 16'h3000);
    chk("addr_hold_rd_1", 101, 16'(mem_read), 16'd1); n_vec++;
    drive(0, 0, 1, 0, 16'h3002, 16'h0000, 16'h0000, 0);
    @(negedge clk); chk("addr_hold_2", 102, mem_address, 16'h3000); n_vec++;
    drive(0, 0, 1, 0, 16'h3002, 16'h0000, 16'h3333, 1);
    @(negedge clk); chk("addr_hold_3", 103, mem_address, 16'h3000);
    chk("addr_hold_resp", 103, 16'(b_resp), 16'd1);
    chk("addr_hold_rdata", 103, b_rdata, 16'h3333); n_vec++;
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    @(negedge clk); chk("addr_hold_done_rd", 104, 16'(mem_read), 16'd0);
    chk("addr_hold_done_state", 104, 16'(dbg_state), 16'(S_I)); n_vec++;

    // b_read and b_write together is a write; exactly one b_resp.
    resp_cnt = 0;
    drive(0, 0, 1, 1, 16'h4000, 16'hCAFE, 16'h0000, 0);
    @(negedge clk); resp_cnt += int'(b_resp);
    drive(0, 0, 1, 1, 16'h4000, 16'hCAFE, 16'h0000, 0);
    @(negedge clk); resp_cnt += int'(b_resp);
    chk("rw_write", 110, 16'(mem_write), 16'd1);
    chk("rw_read", 110, 16'(mem_read), 16'd0);
    chk("rw_wdata", 110, mem_wdata, 16'hCAFE); n_vec++;
    drive(0, 0, 1, 1, 16'h4000, 16'hCAFE, 16'h0000, 1);
    @(negedge clk); resp_cnt += int'(b_resp);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    @(negedge clk); resp_cnt += int'(b_resp);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    @(negedge clk); resp_cnt += int'(b_resp);
    chk("rw_resp_count", 111, 16'(resp_cnt), 16'd1); n_vec++;

    // Reset during a B write: strobe drops immediately, no resp, all zero after release.
    drive(0, 0, 0, 1, 16'h5000, 16'h0101, 16'h0000, 0);
    drive(0, 0, 0, 1, 16'h5000, 16'h0101, 16'h0000, 0);
    @(negedge clk); chk("rst_pre_write", 120, 16'(mem_write), 16'd1); n_vec++;
    #2 rst = 1'b1;
    mem_resp = 1'b1;
    #1;
    chk("rst_write_drop", 121, 16'(mem_write), 16'd0);
    chk("rst_no_bresp", 121, 16'(b_resp), 16'd0);
    chk("rst_state", 121, 16'(dbg_state), 16'(S_I)); n_vec++;
    @(negedge clk);
    b_write = 1'b0; mem_resp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    v = '{default: '0};
    v.x_st = S_I;
    check_all(122, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
